uart_rx: RTL and testbench

UART receiver that deserialises the asynchronous serial line into bytes. It emits one single-cycle strobe per valid frame. It sits directly upstream of the operand-assembly stage: o_data drives that stage's received-byte input and o_rx_done drives its rx-done flag. Sampling is paced by an external 16x-oversampling tick from the shared baud-rate generator.

---
 rtl/uart_rx.sv | 153 +++++++++++++++
 tb/tb_uart_rx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// uart_rx : oversampled UART receiver, one strobe per correctly framed byte
// Rev 1.0 : initial release
// ============================================================================
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int SB_TICK    = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx,
    input  logic                 i_tick,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_frame_err
);

    localparam int S_MAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
    localparam int S_W   = (S_MAX > 2) ? $clog2(S_MAX) : 1;
    localparam int N_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [S_W-1:0] C_S_HALF = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0] C_S_BIT  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] C_S_STOP = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] C_N_LAST = N_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [S_W-1:0]       s_q, s_d;
    logic [N_W-1:0]       n_q, n_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 rx_done_q, rx_done_d;
    logic                 frame_err_q, frame_err_d;
    logic                 sync_q, sync_d;
    logic                 rx_s_q, rx_s_d;

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        n_d         = n_q;
        shift_d     = shift_q;
        data_d      = data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;
        sync_d      = i_rx;
        rx_s_d      = sync_q;

        case (state_q)
            // Start detection is tick-independent so back-to-back frames are caught.
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d = ST_START;
                    s_d     = '0;
                end
            end
            ST_START: begin
                if (i_tick) begin
                    if (s_q == C_S_HALF) begin
                        s_d = '0;
                        if (!rx_s_q) begin
                            state_d = ST_DATA;
                            n_d     = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (i_tick) begin
                    if (s_q == C_S_BIT) begin
                        s_d     = '0;
                        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        if (n_q == C_N_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            n_d = n_q + N_W'(1);
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (i_tick) begin
                    if (s_q == C_S_STOP) begin
                        s_d = '0;
                        if (rx_s_q) begin
                            data_d    = shift_q;
                            rx_done_d = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = ST_BREAK;
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            n_q         <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            sync_q      <= 1'b1;
            rx_s_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
            sync_q      <= sync_d;
            rx_s_q      <= rx_s_d;
        end
    end

    assign o_data      = data_q;
    assign o_rx_done   = rx_done_q;
    assign o_frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_uart_rx : directed bench for uart_rx (SB_TICK 16 and 32 instances)
// Rev 1.0 : initial release
// ============================================================================
module tb_uart_rx;

    localparam int TICK_DIV = 27;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       rx   = 1'b1;
    logic       rx32 = 1'b1;
    logic       tick = 1'b0;
    logic [7:0] data, data32;
    logic       done, ferr, done32, ferr32;

    int tick_div_cnt = 0;
    int tick_total   = 0;
    int n_checks     = 0;
    int n_fails      = 0;
    int done_cnt     = 0;
    int err_cnt      = 0;
    int done32_cnt   = 0;
    int err32_cnt    = 0;
    int viol         = 0;
    logic [7:0] done_data   = 8'h00;
    logic [7:0] done32_data = 8'h00;
    logic       prev_done   = 1'b0;
    logic       prev_err    = 1'b0;
    int         stamps[$];
    logic [7:0] rxq[$];

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .SB_TICK(16)) dut (
        .i_clk(clk), .i_reset(rst), .i_rx(rx), .i_tick(tick),
        .o_data(data), .o_rx_done(done), .o_frame_err(ferr)
    );

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .SB_TICK(32)) dut32 (
        .i_clk(clk), .i_reset(rst), .i_rx(rx32), .i_tick(tick),
        .o_data(data32), .o_rx_done(done32), .o_frame_err(ferr32)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (tick_div_cnt == TICK_DIV - 1) begin
            tick_div_cnt <= 0;
            tick         <= 1'b1;
            tick_total   <= tick_total + 1;
        end else begin
            tick_div_cnt <= tick_div_cnt + 1;
            tick         <= 1'b0;
        end
    end

    // Strobe monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (done) begin
            done_cnt  = done_cnt + 1;
            done_data = data;
            rxq.push_back(data);
            stamps.push_back(tick_total);
        end
        if (ferr) err_cnt = err_cnt + 1;
        if ((done && ferr) || ((done || ferr) && (prev_done || prev_err))) viol = viol + 1;
        prev_done = done;
        prev_err  = ferr;
        if (done32) begin
            done32_cnt  = done32_cnt + 1;
            done32_data = data32;
        end
        if (ferr32) err32_cnt = err32_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int nt);
        for (int i = 0; i < nt; i++) begin
            @(posedge clk);
            while (tick !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_bits(input bit sel, input logic v, input int nt);
        if (sel) rx32 = v;
        else     rx   = v;
        wait_ticks(nt);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop_v, input int stop_ticks);
        send_bits(sel, 1'b0, 16);
        for (int i = 0; i < 8; i++) send_bits(sel, b[i], 16);
        send_bits(sel, stop_v, stop_ticks);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0, d32;
        logic [7:0] exp3 [3];
        exp3[0] = 8'h05; exp3[1] = 8'h10; exp3[2] = 8'h03;

        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_data", data, 8'h00);
        chk("reset_done", done, 1'b0);
        chk("reset_ferr", ferr, 1'b0);
        wait_ticks(4);

        // Single frame 0xA5
        d0 = done_cnt;
        send_frame(0, 8'hA5, 1'b1, 16);
        wait_ticks(4);
        chk("a5_pulses", done_cnt - d0, 1);
        chk("a5_data_at_done", done_data, 8'hA5);
        chk("a5_data_held", data, 8'hA5);
        chk("a5_no_ferr", err_cnt, 0);

        // Back-to-back frames, no idle gap
        rxq.delete();
        stamps.delete();
        d0 = done_cnt;
        send_frame(0, 8'h05, 1'b1, 16);
        send_frame(0, 8'h10, 1'b1, 16);
        send_frame(0, 8'h03, 1'b1, 16);
        wait_ticks(4);
        chk("b2b_pulses", done_cnt - d0, 3);
        for (int i = 0; i < rxq.size() && i < 3; i++) chk($sformatf("b2b_data%0d", i), rxq[i], exp3[i]);
        for (int i = 1; i < stamps.size(); i++)
            chk($sformatf("b2b_gap%0d_in_range", i),
                (stamps[i] - stamps[i-1] >= 159) && (stamps[i] - stamps[i-1] <= 161), 1'b1);

        // 4-tick low glitch on idle line
        d0 = done_cnt;
        e0 = err_cnt;
        send_bits(0, 1'b0, 4);
        send_bits(0, 1'b1, 32);
        chk("glitch_no_done", done_cnt - d0, 0);
        chk("glitch_no_ferr", err_cnt - e0, 0);
        chk("glitch_data_kept", data, 8'h03);
        d0 = done_cnt;
        send_frame(0, 8'h7E, 1'b1, 16);
        wait_ticks(4);
        chk("post_glitch_pulses", done_cnt - d0, 1);
        chk("post_glitch_data", data, 8'h7E);

        // Bad stop bit followed by a 20-bit break
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(0, 8'h3C, 1'b0, 16 + 320);
        chk("ferr_pulses", err_cnt - e0, 1);
        chk("ferr_no_done", done_cnt - d0, 0);
        chk("ferr_data_kept", data, 8'h7E);
        send_bits(0, 1'b1, 32);
        chk("break_no_more_ferr", err_cnt - e0, 1);
        chk("break_no_more_done", done_cnt - d0, 0);
        d0 = done_cnt;
        send_frame(0, 8'h81, 1'b1, 16);
        wait_ticks(4);
        chk("post_break_pulses", done_cnt - d0, 1);
        chk("post_break_data", data, 8'h81);

        // Reset during data bit 4 of 0xFF
        d0 = done_cnt;
        e0 = err_cnt;
        send_bits(0, 1'b0, 16);
        for (int i = 0; i < 4; i++) send_bits(0, 1'b1, 16);
        send_bits(0, 1'b1, 8);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_mid_data", data, 8'h00);
        chk("rst_mid_done", done, 1'b0);
        chk("rst_mid_ferr", ferr, 1'b0);
        send_bits(0, 1'b1, 8 + 3 * 16 + 16 + 16);
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_no_ferr", err_cnt - e0, 0);
        d0 = done_cnt;
        send_frame(0, 8'h42, 1'b1, 16);
        wait_ticks(4);
        chk("post_rst_pulses", done_cnt - d0, 1);
        chk("post_rst_data", data, 8'h42);

        // SB_TICK=32: line low over the 1-stop-bit sample point, high at the final sample
        d32 = done32_cnt;
        send_bits(1, 1'b0, 16);
        for (int i = 0; i < 8; i++) send_bits(1, (8'h5A >> i) & 8'h01, 16);
        send_bits(1, 1'b1, 4);
        send_bits(1, 1'b0, 12);
        send_bits(1, 1'b1, 16);
        wait_ticks(4);
        chk("sb32_pulses", done32_cnt - d32, 1);
        chk("sb32_data", done32_data, 8'h5A);
        chk("sb32_no_ferr", err32_cnt, 0);

        chk("strobe_exclusive_nonconsec", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
